// File: rtl/alucomm_seq_if.sv
// alucomm_seq_if: requester, ALU-control and response signals of the
// alucomm command sequencer; slave = sequencer side, master = environment.
interface alucomm_seq_if #(
    parameter int NREQ = 2,
    parameter int QD   = 4,
    parameter int LWW  = 13,
    parameter int TAGW = 4
);
    localparam int IDW = $clog2(NREQ);
    localparam int QLW = $clog2(QD) + 1;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*8-1:0]    req_func;
    logic [NREQ*32-1:0]   req_opt;
    logic [NREQ*LWW-1:0]  req_alen;
    logic [NREQ*TAGW-1:0] req_tag;
    logic                 flush;
    logic                 alu_start;
    logic [7:0]           alu_func;
    logic [31:0]          alu_opt;
    logic [LWW-1:0]       alu_alen;
    logic                 alu_busy;
    logic                 alu_done;
    logic                 alu_crreg;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [TAGW-1:0]      rsp_tag;
    logic                 rsp_cr;
    logic                 rsp_err;
    logic [QLW-1:0]       q_level;

    modport slave (
        input  req_valid, req_func, req_opt, req_alen, req_tag, flush,
        input  alu_busy, alu_done, alu_crreg, rsp_ready,
        output req_ready, alu_start, alu_func, alu_opt, alu_alen,
        output rsp_valid, rsp_id, rsp_tag, rsp_cr, rsp_err, q_level
    );

    modport master (
        output req_valid, req_func, req_opt, req_alen, req_tag, flush,
        output alu_busy, alu_done, alu_crreg, rsp_ready,
        input  req_ready, alu_start, alu_func, alu_opt, alu_alen,
        input  rsp_valid, rsp_id, rsp_tag, rsp_cr, rsp_err, q_level
    );
endinterface

// File: rtl/alucomm_seq.sv
// alucomm_seq: round-robin command arbiter + FIFO + issue FSM for alucomm.
// Optional watchdog/HALT state enabled by defining ALUSEQ_TIMEOUT_EN.
module alucomm_seq #(
    parameter int NREQ  = 2,
    parameter int QD    = 4,
    parameter int LWW   = 13,
    parameter int TAGW  = 4,
    parameter int TOCYC = 4096
) (
    input  logic         clk,
    input  logic         resetn,
    alucomm_seq_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int PW  = $clog2(QD);
    localparam int QLW = PW + 1;
    localparam logic [IDW:0] NR = (IDW+1)'(NREQ);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [IDW-1:0]  rr_ptr, off, win;
    logic [IDW:0]    sum;
    logic [NREQ-1:0] rot, grant;
    logic            any, can_acc, accept, pop, halt;
    logic [QLW-1:0]  wr_ptr, rd_ptr, level;
    logic            full, empty;

    logic [IDW-1:0]  q_id   [QD];
    logic [TAGW-1:0] q_tag  [QD];
    logic [7:0]      q_func [QD];
    logic [31:0]     q_opt  [QD];
    logic [LWW-1:0]  q_alen [QD];

    logic [IDW-1:0]  h_id;
    logic [TAGW-1:0] h_tag;
    logic [7:0]      h_func;
    logic [31:0]     h_opt;
    logic [LWW-1:0]  h_alen;

    logic [7:0]      op_func;
    logic [31:0]     op_opt;
    logic [LWW-1:0]  op_alen;
    logic [IDW-1:0]  r_id;
    logic [TAGW-1:0] r_tag;
    logic            r_cr, r_err, start_c, rvalid_c;

    // Rotate valids so bit 0 is the requester at rr_ptr, then find first.
    always_comb begin
        rot   = NREQ'({bus.req_valid, bus.req_valid} >> rr_ptr);
        any   = |rot;
        off   = '0;
        grant = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rot[i]) off = IDW'(i);
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= NR) sum = sum - NR;
        win = sum[IDW-1:0];
        for (int k = 0; k < NREQ; k++)
            grant[k] = any && (win == IDW'(k));
    end

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == QLW'(QD));
    assign empty   = (level == '0);
    assign can_acc = ~full & ~bus.flush & ~halt;
    assign accept  = any & can_acc;
    assign pop     = (state == S_IDLE) & ~empty & ~bus.alu_busy & ~bus.flush;

    assign bus.req_ready = grant & {NREQ{can_acc}};
    assign bus.q_level   = level;

    assign h_id   = q_id[rd_ptr[PW-1:0]];
    assign h_tag  = q_tag[rd_ptr[PW-1:0]];
    assign h_func = q_func[rd_ptr[PW-1:0]];
    assign h_opt  = q_opt[rd_ptr[PW-1:0]];
    assign h_alen = q_alen[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr_ptr <= '0;
        end else begin
            if (accept)
                rr_ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (accept) wr_ptr <= wr_ptr + 1'b1;
                if (pop)    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            q_id[wr_ptr[PW-1:0]]   <= win;
            q_tag[wr_ptr[PW-1:0]]  <= bus.req_tag[TAGW*win +: TAGW];
            q_func[wr_ptr[PW-1:0]] <= bus.req_func[8*win +: 8];
            q_opt[wr_ptr[PW-1:0]]  <= bus.req_opt[32*win +: 32];
            q_alen[wr_ptr[PW-1:0]] <= bus.req_alen[LWW*win +: LWW];
        end
    end

`ifdef ALUSEQ_TIMEOUT_EN
    localparam int CW = $clog2(TOCYC) + 1;
    logic [CW-1:0] wd_cnt;
    logic          tmo, op_to;

    assign tmo = (state == S_WAIT) & ~bus.alu_done &
                 (wd_cnt == CW'(TOCYC - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt <= '0;
            op_to  <= 1'b0;
        end else begin
            if (state == S_ISSUE)     wd_cnt <= '0;
            else if (state == S_WAIT) wd_cnt <= wd_cnt + 1'b1;
            if (pop)      op_to <= 1'b0;
            else if (tmo) op_to <= 1'b1;
        end
    end
`else
    logic unused_tocyc;
    assign unused_tocyc = (TOCYC != 0);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:
                if (pop) state_nxt = (h_alen == '0) ? S_RESP : S_ISSUE;
            S_ISSUE:
                state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.alu_done) state_nxt = S_RESP;
`ifdef ALUSEQ_TIMEOUT_EN
                else if (tmo)     state_nxt = S_RESP;
`endif
            end
            S_RESP:
`ifdef ALUSEQ_TIMEOUT_EN
                if (bus.rsp_ready) state_nxt = op_to ? S_HALT : S_IDLE;
            S_HALT:
                if (bus.flush) state_nxt = S_IDLE;
`else
                if (bus.rsp_ready) state_nxt = S_IDLE;
`endif
            default:
                state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start_c  = (state == S_ISSUE);
        rvalid_c = (state == S_RESP);
        halt     = 1'b0;
`ifdef ALUSEQ_TIMEOUT_EN
        halt     = (state == S_HALT);
`endif
    end

    // Op regs keep driving alucomm after the op, since func is decoded live.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_func <= '0;
            op_opt  <= '0;
            op_alen <= '0;
            r_id    <= '0;
            r_tag   <= '0;
            r_cr    <= 1'b0;
            r_err   <= 1'b0;
        end else if (pop) begin
            op_func <= h_func;
            op_opt  <= h_opt;
            op_alen <= h_alen;
            r_id    <= h_id;
            r_tag   <= h_tag;
            r_cr    <= 1'b0;
            r_err   <= (h_alen == '0);
        end else if (state == S_WAIT && bus.alu_done) begin
            r_cr  <= bus.alu_crreg;
            r_err <= 1'b0;
`ifdef ALUSEQ_TIMEOUT_EN
        end else if (tmo) begin
            r_cr  <= 1'b0;
            r_err <= 1'b1;
`endif
        end
    end

    assign bus.alu_start = start_c;
    assign bus.alu_func  = op_func;
    assign bus.alu_opt   = op_opt;
    assign bus.alu_alen  = op_alen;
    assign bus.rsp_valid = rvalid_c;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_tag   = r_tag;
    assign bus.rsp_cr    = r_cr;
    assign bus.rsp_err   = r_err;
endmodule

// File: tb/tb_alucomm_seq.sv
// tb_alucomm_seq: directed checks of arbitration, FIFO, issue FSM, flush,
// response stall and (with ALUSEQ_TIMEOUT_EN) the watchdog/HALT path.
module tb_alucomm_seq;
    localparam int NREQ  = 2;
    localparam int QD    = 4;
    localparam int LWW   = 13;
    localparam int TAGW  = 4;
    localparam int TOCYC = 16;

    logic clk;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    int   starts = 0;
    int   s0;
    logic stable;

    alucomm_seq_if #(.NREQ(NREQ), .QD(QD), .LWW(LWW), .TAGW(TAGW)) bus ();

    alucomm_seq #(
        .NREQ(NREQ), .QD(QD), .LWW(LWW), .TAGW(TAGW), .TOCYC(TOCYC)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.alu_start) starts++;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [7:0] f,
                           input logic [31:0] o, input logic [12:0] a,
                           input logic [3:0] t);
        bus.req_func[8*k +: 8]       = f;
        bus.req_opt[32*k +: 32]      = o;
        bus.req_alen[LWW*k +: LWW]   = a;
        bus.req_tag[TAGW*k +: TAGW]  = t;
    endtask

    initial begin
        resetn        = 1'b0;
        bus.req_valid = '0;
        bus.req_func  = '0;
        bus.req_opt   = '0;
        bus.req_alen  = '0;
        bus.req_tag   = '0;
        bus.flush     = 1'b0;
        bus.alu_busy  = 1'b0;
        bus.alu_done  = 1'b0;
        bus.alu_crreg = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (3) tick();
        chk("rst_start", 64'(bus.alu_start), 64'd0);
        chk("rst_rvalid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_level", 64'(bus.q_level), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_func", 64'(bus.alu_func), 64'd0);
        resetn = 1'b1;
        tick();

        // single ADD from req0
        s0 = starts;
        set_req(0, 8'h02, 32'h0, 13'd256, 4'd3);
        bus.req_valid = 2'b01;
        #1 chk("t1_ready", 64'(bus.req_ready), 64'b01);
        tick();
        bus.req_valid = 2'b00;
        chk("t1_level", 64'(bus.q_level), 64'd1);
        chk("t1_nostart", 64'(bus.alu_start), 64'd0);
        tick();
        chk("t1_start", 64'(bus.alu_start), 64'd1);
        chk("t1_func", 64'(bus.alu_func), 64'h02);
        chk("t1_alen", 64'(bus.alu_alen), 64'd256);
        tick();
        chk("t1_startlo", 64'(bus.alu_start), 64'd0);
        repeat (10) tick();
        bus.alu_done  = 1'b1;
        bus.alu_crreg = 1'b1;
        #1 chk("t1_rv_pre", 64'(bus.rsp_valid), 64'd0);
        tick();
        bus.alu_done  = 1'b0;
        bus.alu_crreg = 1'b0;
        chk("t1_rvalid", 64'(bus.rsp_valid), 64'd1);
        chk("t1_id", 64'(bus.rsp_id), 64'd0);
        chk("t1_tag", 64'(bus.rsp_tag), 64'd3);
        chk("t1_cr", 64'(bus.rsp_cr), 64'd1);
        chk("t1_err", 64'(bus.rsp_err), 64'd0);
        chk("t1_nstart", 64'(starts - s0), 64'd1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("t1_rv_off", 64'(bus.rsp_valid), 64'd0);

        // both requesters valid; rr pointer sits at 1 after req0 won
        bus.alu_busy = 1'b1;
        set_req(0, 8'h03, 32'h11, 13'd0, 4'd1);
        set_req(1, 8'h02, 32'h22, 13'd64, 4'd2);
        bus.req_valid = 2'b11;
        #1 chk("t2_rdy0", 64'(bus.req_ready), 64'b10);
        tick();
        chk("t2_rdy1", 64'(bus.req_ready), 64'b01);
        chk("t2_lvl1", 64'(bus.q_level), 64'd1);
        tick();
        chk("t2_rdy2", 64'(bus.req_ready), 64'b10);
        tick();
        chk("t2_rdy3", 64'(bus.req_ready), 64'b01);
        chk("t2_lvl3", 64'(bus.q_level), 64'd3);
        tick();
        chk("t2_full_rdy", 64'(bus.req_ready), 64'b00);
        chk("t2_full_lvl", 64'(bus.q_level), 64'd4);
        tick();
        chk("t2_hold_lvl", 64'(bus.q_level), 64'd4);
        chk("t2_busy_nostart", 64'(bus.alu_start), 64'd0);
        bus.req_valid = 2'b00;
        bus.alu_busy  = 1'b0;
        tick();
        chk("t2_start", 64'(bus.alu_start), 64'd1);
        chk("t2_alen", 64'(bus.alu_alen), 64'd64);
        chk("t2_lvl", 64'(bus.q_level), 64'd3);
        tick();
        bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        chk("t2_id", 64'(bus.rsp_id), 64'd1);
        chk("t2_tag", 64'(bus.rsp_tag), 64'd2);
        chk("t2_cr", 64'(bus.rsp_cr), 64'd0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // zero-length command from req0 is rejected without a start
        s0 = starts;
        tick();
        chk("t3_rvalid", 64'(bus.rsp_valid), 64'd1);
        chk("t3_err", 64'(bus.rsp_err), 64'd1);
        chk("t3_id", 64'(bus.rsp_id), 64'd0);
        chk("t3_nostart", 64'(bus.alu_start), 64'd0);
        chk("t3_nstart", 64'(starts - s0), 64'd0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        tick();
        chk("t3_next_start", 64'(bus.alu_start), 64'd1);
        chk("t3_next_lvl", 64'(bus.q_level), 64'd1);
        tick();

        // flush in WAIT with three queued; done lands the same cycle
        set_req(0, 8'h04, 32'h33, 13'd32, 4'd5);
        bus.req_valid = 2'b01;
        #1 chk("t4_ready", 64'(bus.req_ready), 64'b01);
        tick();
        tick();
        bus.req_valid = 2'b00;
        chk("t4_lvl3", 64'(bus.q_level), 64'd3);
        bus.req_valid = 2'b01;
        bus.flush     = 1'b1;
        bus.alu_done  = 1'b1;
        bus.alu_crreg = 1'b1;
        #1 chk("t4_flush_rdy", 64'(bus.req_ready), 64'b00);
        tick();
        bus.req_valid = 2'b00;
        bus.flush     = 1'b0;
        bus.alu_done  = 1'b0;
        bus.alu_crreg = 1'b0;
        s0 = starts;
        chk("t4_lvl0", 64'(bus.q_level), 64'd0);
        chk("t4_rvalid", 64'(bus.rsp_valid), 64'd1);
        chk("t4_id", 64'(bus.rsp_id), 64'd1);
        chk("t4_cr", 64'(bus.rsp_cr), 64'd1);
        chk("t4_err", 64'(bus.rsp_err), 64'd0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        repeat (5) tick();
        chk("t4_nstart", 64'(starts - s0), 64'd0);
        chk("t4_lvl_end", 64'(bus.q_level), 64'd0);
        bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        chk("idle_done_ign", 64'(bus.rsp_valid), 64'd0);

        // response stall; unknown func passes through
        set_req(1, 8'h55, 32'h44, 13'd8, 4'd7);
        set_req(0, 8'h03, 32'h55, 13'd16, 4'd9);
        bus.req_valid = 2'b11;
        #1 chk("t5_rdy_a", 64'(bus.req_ready), 64'b10);
        tick();
        chk("t5_rdy_b", 64'(bus.req_ready), 64'b01);
        tick();
        bus.req_valid = 2'b00;
        chk("t5_pushpop_lvl", 64'(bus.q_level), 64'd1);
        chk("t5_start", 64'(bus.alu_start), 64'd1);
        chk("t5_func", 64'(bus.alu_func), 64'h55);
        tick();
        bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        chk("t5_tag", 64'(bus.rsp_tag), 64'd7);
        chk("t5_err", 64'(bus.rsp_err), 64'd0);
        s0 = starts;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'd7 ||
                bus.rsp_id !== 1'b1 || bus.alu_func !== 8'h55)
                stable = 1'b0;
        end
        chk("t5_stable", 64'(stable), 64'd1);
        chk("t5_nstart", 64'(starts - s0), 64'd0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("t5_gap_start", 64'(bus.alu_start), 64'd0);
        tick();
        chk("t5_next_start", 64'(bus.alu_start), 64'd1);
        chk("t5_next_func", 64'(bus.alu_func), 64'h03);
        chk("t5_next_alen", 64'(bus.alu_alen), 64'd16);
        tick();
        bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        chk("t5_next_tag", 64'(bus.rsp_tag), 64'd9);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

`ifdef ALUSEQ_TIMEOUT_EN
        // watchdog: no done, error response, HALT until flush
        set_req(0, 8'h02, 32'h66, 13'd8, 4'd4);
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();
        repeat (15) tick();
        chk("t6_pre_to", 64'(bus.rsp_valid), 64'd0);
        tick();
        chk("t6_rvalid", 64'(bus.rsp_valid), 64'd1);
        chk("t6_err", 64'(bus.rsp_err), 64'd1);
        chk("t6_cr", 64'(bus.rsp_cr), 64'd0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 2'b01;
        #1 chk("t6_halt_rdy", 64'(bus.req_ready), 64'b00);
        bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        chk("t6_halt_lvl", 64'(bus.q_level), 64'd0);
        chk("t6_halt_rv", 64'(bus.rsp_valid), 64'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1 chk("t6_resume_rdy", 64'(bus.req_ready), 64'b01);
        tick();
        bus.req_valid = 2'b00;
        tick();
        chk("t6_resume_start", 64'(bus.alu_start), 64'd1);
`endif

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
